alu_mdu: RTL

- Parametrised successor to the single-cycle integer ALU.
- Same base operation set, generalised to XLEN, plus RV32M/RV64M multiply/divide/remainder executed iteratively.
- Registered valid/ready handshake on both sides; sits in the execute stage, and the pipeline stalls on in_ready/out_valid.

---
 rtl/alu_pkg.sv | 50 +++++
 rtl/alu_mdu_if.sv | 32 +++
 rtl/alu_base.sv | 35 +++
 rtl/alu_mdu.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage integer unit: opcode constants,
// the sequencing FSM state type, and the operand-signedness rule of the M ops.
package alu_pkg;

    // Base ALU codes, carried in op[3:0] when op[4] = 0.
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SRA  = 4'b1101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;

    // M-extension funct3 codes, carried in op[2:0] when op[4] = 1.
    localparam logic [2:0] MDU_MUL    = 3'd0;
    localparam logic [2:0] MDU_MULH   = 3'd1;
    localparam logic [2:0] MDU_MULHSU = 3'd2;
    localparam logic [2:0] MDU_MULHU  = 3'd3;
    localparam logic [2:0] MDU_DIV    = 3'd4;
    localparam logic [2:0] MDU_DIVU   = 3'd5;
    localparam logic [2:0] MDU_REM    = 3'd6;
    localparam logic [2:0] MDU_REMU   = 3'd7;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MUL  = 3'd1,
        DIV  = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } state_t;

    // Returns {a_is_signed, b_is_signed} for an M op. Plain mul treats both
    // operands as unsigned: the low half of the product is sign-agnostic.
    function automatic logic [1:0] m_signs(input logic [2:0] f3);
        logic [1:0] s;
        s = 2'b00;
        case (f3)
            MDU_MULH:   s = 2'b11;
            MDU_MULHSU: s = 2'b10;
            MDU_DIV:    s = 2'b11;
            MDU_REM:    s = 2'b11;
            default:    s = 2'b00;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/alu_mdu_if.sv
// Request/response bundle between the pipeline and the integer unit.
//
// Handshake: a request transfers on a rising edge where in_valid && in_ready;
// a response transfers on a rising edge where out_valid && out_ready. in_ready
// depends on unit state only. Once out_valid rises, result and out_valid stay
// stable until the transfer (or a flush/reset).
interface alu_mdu_if #(
    parameter int XLEN = 32
);
    import alu_pkg::*;

    logic            in_valid;
    logic            in_ready;
    logic [4:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            busy;
    state_t          dbg_state;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, busy, dbg_state
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, busy, dbg_state
    );
endinterface

// File: rtl/alu_base.sv
// Combinational XLEN-wide base ALU (add/sub/shift/compare/logic).
module alu_base
    import alu_pkg::*;
#(
    parameter  int XLEN = 32,
    localparam int SHW  = $clog2(XLEN)
) (
    input  logic [3:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] y
);

    logic [SHW-1:0] shamt;
    assign shamt = b[SHW-1:0];

    // Operation select; unknown codes fall back to add.
    always_comb begin
        y = a + b;
        case (op)
            ALU_ADD:  y = a + b;
            ALU_SUB:  y = a - b;
            ALU_SLL:  y = a << shamt;
            ALU_SLT:  y = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLTU: y = {{(XLEN-1){1'b0}}, (a < b)};
            ALU_XOR:  y = a ^ b;
            ALU_SRL:  y = a >> shamt;
            ALU_SRA:  y = $signed(a) >>> shamt;
            ALU_OR:   y = a | b;
            ALU_AND:  y = a & b;
            default:  y = a + b;
        endcase
    end

endmodule

// File: rtl/alu_mdu.sv
// Execute-stage integer unit: single-cycle base ALU plus iterative
// multiply/divide (radix-2 shift-add and restoring division on magnitudes,
// followed by one sign-fix cycle). One op in flight at a time.
module alu_mdu
    import alu_pkg::*;
#(
    parameter  int XLEN = 32,
    localparam int SHW  = $clog2(XLEN)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       flush,
    alu_mdu_if.slave   bus
);

    state_t state, state_nx;

    // acc: MUL -> {partial product high, multiplier shifting out low}
    //      DIV -> {partial remainder, dividend shifting into quotient}
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   opnd;       // multiplicand or divisor magnitude
    logic [SHW-1:0]    cnt;        // shared iteration counter
    logic [XLEN-1:0]   result_q;
    logic [2:0]        f3_q;
    logic              neg_q;      // product/quotient must be negated
    logic              rem_neg_q;  // remainder must be negated

    // ---------------- request decode ----------------
    logic            accept;
    logic            is_m;
    logic            is_div;
    logic [2:0]      f3;
    logic [1:0]      sg;
    logic            a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag;
    logic            div_zero, div_ovf, special;
    logic [XLEN-1:0] special_res;
    logic [XLEN-1:0] base_y;

    assign accept   = bus.in_valid && (state == IDLE) && !flush;
    assign is_m     = bus.op[4];
    assign f3       = bus.op[2:0];
    assign is_div   = f3[2];
    assign sg       = m_signs(f3);
    assign a_neg    = sg[1] & bus.a[XLEN-1];
    assign b_neg    = sg[0] & bus.b[XLEN-1];
    assign a_mag    = a_neg ? (~bus.a + 1'b1) : bus.a;
    assign b_mag    = b_neg ? (~bus.b + 1'b1) : bus.b;
    assign div_zero = (bus.b == '0);
    assign div_ovf  = sg[1] && (bus.a == {1'b1, {(XLEN-1){1'b0}}}) && (bus.b == '1);
    assign special  = is_div && (div_zero || div_ovf);

    // Results of the division corner cases that skip iteration.
    always_comb begin
        special_res = '0;
        if (f3 == MDU_DIV || f3 == MDU_DIVU) begin
            special_res = div_zero ? '1 : bus.a;
        end else begin
            special_res = div_zero ? bus.a : '0;
        end
    end

    alu_base #(.XLEN(XLEN)) u_base (
        .op (bus.op[3:0]),
        .a  (bus.a),
        .b  (bus.b),
        .y  (base_y)
    );

    // ---------------- iteration datapath ----------------
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_shift;
    logic              div_ge;
    logic [XLEN-1:0]   div_diff;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   fix_res;

    assign mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
    assign div_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    assign div_ge    = (div_shift >= {1'b0, opnd});
    assign div_diff  = div_shift[XLEN-1:0] - opnd;
    assign prod      = neg_q ? (~acc + 1'b1) : acc;

    // Sign correction and half selection applied in FIX.
    always_comb begin
        fix_res = '0;
        case (f3_q)
            MDU_MUL:                          fix_res = prod[XLEN-1:0];
            MDU_MULH, MDU_MULHSU, MDU_MULHU:  fix_res = prod[2*XLEN-1:XLEN];
            MDU_DIV, MDU_DIVU:                fix_res = neg_q ? (~acc[XLEN-1:0] + 1'b1) : acc[XLEN-1:0];
            default:                          fix_res = rem_neg_q ? (~acc[2*XLEN-1:XLEN] + 1'b1)
                                                                  : acc[2*XLEN-1:XLEN];
        endcase
    end

    // ---------------- FSM ----------------
    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Next-state logic; flush overrides every other transition.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (!is_m)        state_nx = DONE;
                    else if (!is_div) state_nx = MUL;
                    else if (special) state_nx = DONE;
                    else              state_nx = DIV;
                end
            end
            MUL, DIV: if (cnt == SHW'(XLEN-1)) state_nx = FIX;
            FIX:      state_nx = DONE;
            DONE:     if (bus.out_ready) state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
        if (flush) state_nx = IDLE;
    end

    // Operand capture, iteration steps and result registration.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc       <= '0;
            opnd      <= '0;
            cnt       <= '0;
            result_q  <= '0;
            f3_q      <= '0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
        end else if (flush) begin
            cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        cnt       <= '0;
                        f3_q      <= f3;
                        neg_q     <= a_neg ^ b_neg;
                        rem_neg_q <= a_neg;
                        if (!is_m) begin
                            result_q <= base_y;
                        end else if (!is_div) begin
                            acc  <= {{XLEN{1'b0}}, b_mag};
                            opnd <= a_mag;
                        end else if (special) begin
                            result_q <= special_res;
                        end else begin
                            acc  <= {{XLEN{1'b0}}, a_mag};
                            opnd <= b_mag;
                        end
                    end
                end
                MUL: begin
                    acc <= {mul_sum, acc[XLEN-1:1]};
                    cnt <= cnt + 1'b1;
                end
                DIV: begin
                    acc <= {(div_ge ? div_diff : div_shift[XLEN-1:0]), acc[XLEN-2:0], div_ge};
                    cnt <= cnt + 1'b1;
                end
                FIX:     result_q <= fix_res;
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.busy      = (state != IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.result    = result_q;
    assign bus.dbg_state = state;

endmodule
